blink_meter: RTL and testbench

Measures an incoming blink/square-wave signal, such as an LED drive or an external 1 Hz tick. It reports the period and the high time in clock cycles, pulses a valid strobe per completed period, and flags loss of activity. It is the input-side counterpart of the team's LED blink generators and is used to close the loop on blink outputs and to time external periodic sources.

---
 rtl/blink_pkg.sv | 17 +
 rtl/sync_edge.sv | 41 ++++
 rtl/blink_meter.sv | 103 ++++++++++
 tb/tb_blink_meter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/blink_pkg.sv
// Shared types and helpers for blink_meter: FSM state, default clock, counter sizing.
package blink_pkg;

  typedef enum logic {IDLE, MEASURE} state_t;

  localparam int unsigned DEF_CLK_FREQ = 50_000_000;

  // Smallest width w with 2**w > n (at least 1).
  function automatic int unsigned cnt_width(input longint unsigned n);
    int unsigned w;
    w = 1;
    for (int unsigned i = 0; i < 63; i++)
      if ((64'd1 << i) <= n) w = i + 1;
    return w;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Input conditioning for blink_meter: optional two-flop synchronizer (BLINK_METER_SYNC_EN),
// delay register and rise/fall strobes.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic rise,
  output logic fall
);

  logic s;
  logic d;

`ifdef BLINK_METER_SYNC_EN
  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      s    <= 1'b0;
    end else begin
      meta <= sig_in;
      s    <= meta;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) s <= 1'b0;
    else     s <= sig_in;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) d <= 1'b0;
    else     d <= s;
  end

  assign rise = s & ~d;
  assign fall = ~s & d;

endmodule

// File: rtl/blink_meter.sv
// Period / high-time meter for a blink or square-wave input with timeout detection.
// Synchronizer depth is selected by BLINK_METER_SYNC_EN (see sync_edge).
module blink_meter
  import blink_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ,
  parameter int unsigned MAX_PERIOD = 2 * CLK_FREQ,
  parameter int unsigned CNT_W      = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             timeout
);

  if (CNT_W < cnt_width(MAX_PERIOD)) begin : g_cnt_w_check
    $error("blink_meter: CNT_W too small for MAX_PERIOD");
  end
  if (CLK_FREQ == 0) begin : g_clk_check
    $error("blink_meter: CLK_FREQ must be non-zero");
  end

  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] MAXC = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] THR  = CNT_W'(MAX_PERIOD - 1);

  state_t           state, state_n;
  logic             rise, fall;
  logic [CNT_W-1:0] cnt, cnt_inc, high_lat;
  logic             do_meas, do_tmo, do_fall;

  sync_edge u_sync_edge (
    .clk    (clk),
    .rst    (rst),
    .sig_in (sig_in),
    .rise   (rise),
    .fall   (fall)
  );

  assign cnt_inc = cnt + ONE;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // A rise in the threshold cycle is a normal measurement, not a timeout.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (rise) state_n = MEASURE;
      MEASURE: if (!rise && cnt == THR) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    do_meas = 1'b0;
    do_tmo  = 1'b0;
    do_fall = 1'b0;
    if (state == MEASURE) begin
      do_meas = rise;
      do_tmo  = !rise && cnt == THR;
      do_fall = fall;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      high_lat  <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      locked    <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      if (rise)
        cnt <= '0;
      else if (state == MEASURE && cnt != MAXC)
        cnt <= cnt_inc;

      if (do_fall) high_lat <= cnt_inc;

      valid <= do_meas;
      if (do_meas) begin
        period    <= cnt_inc;
        high_time <= high_lat;
        locked    <= 1'b1;
        timeout   <= 1'b0;
      end
      if (do_tmo) begin
        timeout <= 1'b1;
        locked  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_blink_meter.sv
// Scoreboard bench for blink_meter: driver queues expected measurements, monitor checks each valid.
module tb_blink_meter;

  localparam int unsigned CLKF = 100;
  localparam int unsigned MAXP = 50;
  localparam int unsigned W    = 8;
`ifdef BLINK_METER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sig_in = 1'b0;
  logic [W-1:0] period, high_time;
  logic         valid, locked, timeout;

  typedef struct {
    int p;
    int h;
    int e;
  } exp_t;

  exp_t sb[$];
  int   edge_cnt = 0;
  int   last_valid_edge = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  blink_meter #(.CLK_FREQ(CLKF), .MAX_PERIOD(MAXP), .CNT_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .sig_in    (sig_in),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .locked    (locked),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Monitor: every valid must match the oldest queued expectation.
  always @(negedge clk) begin
    if (valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid: got valid at edge %0d, want none", edge_cnt);
      end else begin
        exp_t x;
        x = sb.pop_front();
        check("sb_period", int'(period), x.p);
        check("sb_high_time", int'(high_time), x.h);
        check("sb_valid_edge", edge_cnt, x.e);
        check("sb_locked", int'(locked), 1);
        check("sb_timeout", int'(timeout), 0);
      end
      last_valid_edge = edge_cnt;
    end
  end

  // Drive one cycle; a pushed rise is expected to report LAT edges after its sampling edge.
  task automatic step(input logic v, input bit push, input int p, input int h);
    if (push) sb.push_back('{p, h, edge_cnt + 1 + LAT});
    sig_in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic square(input int h, input int l, input int n,
                        input bit fpush, input int fp, input int fh);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < h; i++)
        step(1'b1, (i == 0) && (k > 0 || fpush), (k == 0) ? fp : h + l, (k == 0) ? fh : h);
      for (int i = 0; i < l; i++)
        step(1'b0, 1'b0, 0, 0);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_period"}, int'(period), 0);
    check({tag, "_high_time"}, int'(high_time), 0);
    check({tag, "_valid"}, int'(valid), 0);
    check({tag, "_locked"}, int'(locked), 0);
    check({tag, "_timeout"}, int'(timeout), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) step(1'b0, 1'b0, 0, 0);
    check_zero("reset");
    rst = 1'b0;
    repeat (2) step(1'b0, 1'b0, 0, 0);

    // 6 high / 4 low, 5 periods: first rise arms, next four report 10/6.
    square(6, 4, 5, 1'b0, 0, 0);
    check("wave_locked", int'(locked), 1);
    check("wave_timeout", int'(timeout), 0);

    // Hold low: timeout exactly MAXP edges after the last reporting edge.
    while (edge_cnt < last_valid_edge + int'(MAXP) - 1) step(1'b0, 1'b0, 0, 0);
    check("pre_timeout", int'(timeout), 0);
    step(1'b0, 1'b0, 0, 0);
    check("timeout_set", int'(timeout), 1);
    check("timeout_locked", int'(locked), 0);
    check("timeout_period_hold", int'(period), 10);
    check("timeout_high_hold", int'(high_time), 6);

    // Restart: first rise silent and timeout stays; second rise reports and clears it.
    square(6, 4, 1, 1'b0, 0, 0);
    check("restart_timeout_kept", int'(timeout), 1);
    check("restart_locked_low", int'(locked), 0);
    square(6, 4, 1, 1'b1, 10, 6);
    check("restart_timeout_clr", int'(timeout), 0);
    check("restart_locked", int'(locked), 1);

    // Minimum period: alternate every cycle.
    square(1, 1, 6, 1'b1, 10, 6);

    // Reset in the middle of a high phase.
    step(1'b1, 1'b1, 2, 1);
    step(1'b1, 1'b0, 0, 0);
    step(1'b1, 1'b0, 0, 0);
    rst = 1'b1;
    step(1'b0, 1'b0, 0, 0);
    check_zero("midrst");
    step(1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 0, 0);
    rst = 1'b0;
    square(6, 4, 3, 1'b0, 0, 0);

    // Period exactly MAXP: rise lands on the timeout threshold and wins.
    square(20, 30, 2, 1'b1, 10, 6);
    step(1'b1, 1'b1, 50, 20);
    step(1'b1, 1'b0, 0, 0);
    step(1'b1, 1'b0, 0, 0);
    check("maxp_timeout", int'(timeout), 0);
    check("maxp_locked", int'(locked), 1);
    check("maxp_period", int'(period), 50);

    repeat (4) step(1'b0, 1'b0, 0, 0);
    check("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
